// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: types and constants shared by the MEM-stage data-memory
// sequencer, its timeout counter and the MEM/WB pipeline register.
//   mem_state_e      - sequencer states (IDLE, BUSY, DONE)
//   DEFAULT_TIMEOUT  - BUSY cycles allowed before an access is abandoned
//   BUBBLE_*         - control bits MEM/WB loads while wb_bubble is high
package mem_ctrl_pkg;

  localparam int DEFAULT_TIMEOUT = 16;

  // A bubble must not write the register file or select memory data.
  localparam logic BUBBLE_REGWRITE = 1'b0;
  localparam logic BUBBLE_MEMTOREG = 1'b0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/dmem_timeout_ctr.sv
// dmem_timeout_ctr: saturating BUSY-cycle counter for the data-memory
// sequencer.
//   clk_i      - clock
//   reset_i    - asynchronous active-high reset
//   clear_i    - restart count at 0 (wins over enable_i)
//   enable_i   - count this cycle
//   expired_o  - count has reached TIMEOUT-1 (last BUSY cycle allowed)
module dmem_timeout_ctr
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && (cnt_q != CW'(TIMEOUT)))  // hold at TIMEOUT, never wrap
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: MEM-stage data-memory sequencer. Each load/store seen on
// EX/MEM becomes one req/ready handshake; the pipeline is frozen and MEM/WB
// fed bubbles until the access completes or times out.
//   clk, reset                 - clock, asynchronous active-high reset
//   MemWrite_mem, MemToReg_mem - store / load request from EX/MEM
//   ALUResult_mem              - byte address from EX/MEM
//   MemWriteData_mem           - store data from EX/MEM
//   stall_pipe                 - hold PC, IF/ID, ID/EX, EX/MEM
//   wb_bubble                  - MEM/WB captures a bubble
//   MemReadData_mem            - last load result (0 on a timed-out load)
//   mem_error                  - sticky timeout flag
//   dmem_req/we/addr/wdata     - memory request side (registered)
//   dmem_rdata, dmem_ready     - memory response side
module dmem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemWrite_mem,
  input  logic              MemToReg_mem,
  input  logic [DATA_W-1:0] ALUResult_mem,
  input  logic [DATA_W-1:0] MemWriteData_mem,
  output logic              stall_pipe,
  output logic              wb_bubble,
  output logic [DATA_W-1:0] MemReadData_mem,
  output logic              mem_error,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ready
);

  mem_state_e        state_q, state_d;
  logic              we_q, err_q;
  logic [DATA_W-1:0] addr_q, wdata_q, rdata_q;
  logic              access, launch, busy, hold, expired;

  assign access = MemWrite_mem | MemToReg_mem;
  assign busy   = (state_q == BUSY);

  dmem_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i     (clk),
    .reset_i   (reset),
    .clear_i   (launch),
    .enable_i  (busy),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    hold    = 1'b0;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: if (access) begin
        hold    = 1'b1;
        launch  = 1'b1;
        state_d = BUSY;
      end
      BUSY: begin
        hold = 1'b1;
        if (dmem_ready || expired) state_d = DONE;
      end
      DONE:    state_d = IDLE;  // new access only evaluated back in IDLE
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (launch) begin
        addr_q  <= ALUResult_mem;
        wdata_q <= MemWriteData_mem;
        we_q    <= MemWrite_mem;  // both bits set -> write
      end
      if (busy) begin
        // ready on the expiry cycle still counts as success
        if (dmem_ready) begin
          if (!we_q) rdata_q <= dmem_rdata;
        end else if (expired) begin
          err_q <= 1'b1;
          if (!we_q) rdata_q <= '0;
        end
      end
    end
  end

  // hold is combinational from IDLE+access, so mask it while in reset
  assign stall_pipe      = hold & ~reset;
  assign wb_bubble       = hold & ~reset;
  assign dmem_req        = busy;
  assign dmem_we         = we_q;
  assign dmem_addr       = addr_q;
  assign dmem_wdata      = wdata_q;
  assign MemReadData_mem = rdata_q;
  assign mem_error       = err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;
  localparam int TO = 16;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MemWrite_mem = 1'b0, MemToReg_mem = 1'b0;
  logic [DW-1:0] ALUResult_mem = '0, MemWriteData_mem = '0;
  logic          stall_pipe, wb_bubble, mem_error, dmem_req, dmem_we;
  logic [DW-1:0] MemReadData_mem, dmem_addr, dmem_wdata;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_ready = 1'b0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.TIMEOUT(TO), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .MemWrite_mem(MemWrite_mem), .MemToReg_mem(MemToReg_mem),
    .ALUResult_mem(ALUResult_mem), .MemWriteData_mem(MemWriteData_mem),
    .stall_pipe(stall_pipe), .wb_bubble(wb_bubble),
    .MemReadData_mem(MemReadData_mem), .mem_error(mem_error),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready)
  );

  typedef struct {
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd_exp;
    logic          err_exp;
    int            req_cyc;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   errors  = 0;

  // reference model state
  logic [DW-1:0] m_rd  = '0;
  logic          m_err = 1'b0;

  // memory responder state
  int            lat_cur = 0;
  int            busy_n  = 0;
  logic [DW-1:0] rdat_cur = '0;
  int            stray_mode = 0;  // 0: random stray ready, 1: forced high

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // advance one cycle, then play the memory for the new cycle
  task automatic tick();
    @(posedge clk); #1;
    if (dmem_req) begin
      busy_n++;
      dmem_ready = (lat_cur != 0) && (busy_n == lat_cur);
      dmem_rdata = dmem_ready ? rdat_cur : DW'($urandom);
    end else begin
      dmem_ready = (stray_mode == 1) ? 1'b1 : 1'($urandom % 2);
      dmem_rdata = DW'($urandom);
    end
  endtask

  // lat == 0 means the memory never answers
  task automatic do_txn(input logic we, input logic rd, input logic [DW-1:0] addr,
                        input logic [DW-1:0] wd, input int lat, input logic [DW-1:0] rdat);
    exp_t e;
    bit   to, done;
    tick();
    to = (lat == 0) || (lat > TO);
    if (!we) m_rd = to ? '0 : rdat;
    if (to) m_err = 1'b1;
    e.we = we; e.addr = addr; e.wdata = wd; e.rd_exp = m_rd;
    e.err_exp = m_err; e.req_cyc = to ? TO : lat;
    sbq.push_back(e);
    lat_cur = lat; rdat_cur = rdat; busy_n = 0;
    MemWrite_mem = we; MemToReg_mem = rd;
    ALUResult_mem = addr; MemWriteData_mem = wd;
    done = 0;
    for (int n = 0; n < 60 && !done; n++) begin
      tick();
      if (busy_n > 0 && !dmem_req) done = 1;  // now in the completion cycle
    end
    if (!done) chk("txn_completion_bound", 64'd0, 64'd1);
  endtask

  task automatic idle(input int n);
    tick();
    MemWrite_mem = 0; MemToReg_mem = 0;
    ALUResult_mem = DW'($urandom); MemWriteData_mem = DW'($urandom);
    for (int i = 1; i < n; i++) tick();
  endtask

  // scoreboard monitor
  bit in_txn = 0;
  int req_n = 0, stall_n = 0, bub_n = 0;
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      in_txn = 0;
    end else if (stall_pipe) begin
      if (!in_txn) begin
        in_txn = 1; req_n = 0; stall_n = 0; bub_n = 0;
        vectors++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_access: stall with no pending instruction (t=%0t)", $time);
        end
      end
      stall_n++;
      if (wb_bubble) bub_n++;
      if (dmem_req && sbq.size() > 0) begin
        req_n++;
        chk("req_addr", 64'(dmem_addr), 64'(sbq[0].addr));
        chk("req_we", 64'(dmem_we), 64'(sbq[0].we));
        if (sbq[0].we) chk("req_wdata", 64'(dmem_wdata), 64'(sbq[0].wdata));
      end
    end else if (in_txn) begin
      in_txn = 0;
      chk("done_bubble", 64'(wb_bubble), 64'd0);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("req_cycles", 64'(req_n), 64'(e.req_cyc));
        chk("stall_cycles", 64'(stall_n), 64'(e.req_cyc + 1));
        chk("bubble_cycles", 64'(bub_n), 64'(e.req_cyc + 1));
        chk("read_data", 64'(MemReadData_mem), 64'(e.rd_exp));
        chk("mem_error", 64'(mem_error), 64'(e.err_exp));
      end
    end
  end

  initial begin
    logic we, rd;
    int   lat;
    // reset state, with an access pending to prove stall is masked
    MemWrite_mem = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 64'(stall_pipe), 64'd0);
    chk("rst_bubble", 64'(wb_bubble), 64'd0);
    chk("rst_req", 64'(dmem_req), 64'd0);
    chk("rst_we", 64'(dmem_we), 64'd0);
    chk("rst_addr", 64'(dmem_addr), 64'd0);
    chk("rst_wdata", 64'(dmem_wdata), 64'd0);
    chk("rst_rdata", 64'(MemReadData_mem), 64'd0);
    chk("rst_err", 64'(mem_error), 64'd0);
    MemWrite_mem = 0;
    @(posedge clk); #1;
    reset = 0;

    do_txn(0, 1, 32'h0000_0040, 32'h0, 1, 32'hCAFE_0001);
    do_txn(1, 0, 32'h0000_0080, 32'h1234_5678, 4, 32'h0);
    do_txn(0, 1, 32'h0000_0100, 32'h0, 1, 32'hBEEF_0002);   // back-to-back
    do_txn(1, 0, 32'h0000_0104, 32'hA5A5_5A5A, 1, 32'h0);
    do_txn(1, 1, 32'h0000_0200, 32'h0F0F_F0F0, 2, 32'hDEAD_0003);  // both bits: write
    idle(6);                                                  // stray ready
    chk("stray_rdata_held", 64'(MemReadData_mem), 64'hBEEF_0002);
    do_txn(0, 1, 32'h0000_0300, 32'h0, TO, 32'h1111_2222);   // ready on expiry cycle
    do_txn(0, 1, 32'h0000_0400, 32'h0, 0, 32'h0);            // timeout
    idle(3);
    chk("err_sticky", 64'(mem_error), 64'd1);

    // reset in the 2nd BUSY cycle of a latency-5 read
    tick();
    lat_cur = 5; busy_n = 0; rdat_cur = 32'h7777_7777;
    begin
      exp_t e;
      e.we = 0; e.addr = 32'h500; e.wdata = 0; e.rd_exp = 0; e.err_exp = 0; e.req_cyc = 5;
      sbq.push_back(e);
    end
    MemToReg_mem = 1; ALUResult_mem = 32'h500;
    for (int n = 0; n < 10 && busy_n < 2; n++) tick();
    chk("pre_reset_req", 64'(dmem_req), 64'd1);
    reset = 1;
    sbq.delete();
    m_rd = '0; m_err = 1'b0;
    #1;
    chk("arst_req", 64'(dmem_req), 64'd0);
    chk("arst_stall", 64'(stall_pipe), 64'd0);
    chk("arst_err", 64'(mem_error), 64'd0);
    MemToReg_mem = 0;
    tick(); tick();
    reset = 0;
    stray_mode = 1;
    repeat (3) begin
      tick();
      chk("late_ready_req", 64'(dmem_req), 64'd0);
      chk("late_ready_stall", 64'(stall_pipe), 64'd0);
      chk("late_ready_rdata", 64'(MemReadData_mem), 64'd0);
    end
    stray_mode = 0;

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      if ($urandom % 3 == 0) idle(int'($urandom_range(1, 3)));
      we = 1'($urandom); rd = 1'($urandom);
      if (!we && !rd) rd = 1;
      case ($urandom % 12)
        0:       lat = 0;
        1:       lat = TO;
        default: lat = int'($urandom_range(1, 6));
      endcase
      do_txn(we, rd, DW'($urandom), DW'($urandom), lat, DW'($urandom));
    end
    idle(4);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
